// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared op/state encodings and default width for shift_unit_seq
package shift_pkg;

  localparam int SHIFT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_unit_seq_step.sv
// rtl/shift_unit_seq_step.sv - combinational 1-or-2 bit shift step (rotate only with MIPS_SHIFT_ROTR_EN)
module shift_unit_seq_step
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH
) (
  input  logic [WIDTH-1:0] i_acc,
  input  op_e              i_op,
  input  logic             i_step2,
  output logic [WIDTH-1:0] o_acc
);

  always_comb begin
    o_acc = i_acc;
    case (i_op)
      OP_SLL: o_acc = i_step2 ? {i_acc[WIDTH-3:0], 2'b00} : {i_acc[WIDTH-2:0], 1'b0};
      OP_SRL: o_acc = i_step2 ? {2'b00, i_acc[WIDTH-1:2]} : {1'b0, i_acc[WIDTH-1:1]};
      OP_SRA: o_acc = i_step2 ? {{2{i_acc[WIDTH-1]}}, i_acc[WIDTH-1:2]}
                              : {i_acc[WIDTH-1], i_acc[WIDTH-1:1]};
`ifdef MIPS_SHIFT_ROTR_EN
      OP_ROTR: o_acc = i_step2 ? {i_acc[1:0], i_acc[WIDTH-1:2]} : {i_acc[0], i_acc[WIDTH-1:1]};
`endif
      default: o_acc = i_acc;
    endcase
  end

endmodule

// File: rtl/shift_unit_seq.sv
// rtl/shift_unit_seq.sv - iterative 2-bit-per-cycle shifter with start/busy/done handshake
// Optional rotate-right on op=11 when MIPS_SHIFT_ROTR_EN is defined.
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  state_e           r_state;
  state_e           w_next;
  op_e              r_op;
  logic [SHW-1:0]   r_cnt;
  logic [SHW-1:0]   w_cnt_dec;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] w_step_acc;
  logic             r_busy;
  logic             r_done;
  logic             w_accept;
  logic             w_skip;
  logic             w_step2;

  assign w_accept  = start && (r_state != SHIFT);
  assign w_step2   = (r_cnt >= SHW'(2));
  assign w_cnt_dec = r_cnt - (w_step2 ? SHW'(2) : SHW'(1));

  // Requests needing no shifting go straight to DONE.
`ifdef MIPS_SHIFT_ROTR_EN
  assign w_skip = (shamt == '0);
`else
  assign w_skip = (shamt == '0) || (op_e'(op) == OP_ROTR);
`endif

  shift_unit_seq_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_acc   (r_acc),
    .i_op    (r_op),
    .i_step2 (w_step2),
    .o_acc   (w_step_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          w_next = w_skip ? DONE : SHIFT;
        end else begin
          w_next = IDLE;
        end
      end
      SHIFT: begin
        if (w_cnt_dec == '0) begin
          w_next = DONE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_op   <= OP_SLL;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dout <= '0;
    end else begin
      if (w_accept) begin
        r_acc <= din;
        r_op  <= op_e'(op);
        r_cnt <= shamt;
      end else if (r_state == SHIFT) begin
        r_acc <= w_step_acc;
        r_cnt <= w_cnt_dec;
      end
      r_busy <= (w_next == SHIFT);
      // done and dout trail the DONE state by one edge; r_acc still holds the result here.
      r_done <= (r_state == DONE);
      if (r_state == DONE) begin
        r_dout <= r_acc;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign dout = r_dout;

endmodule

// File: tb/tb_shift_unit_seq.sv
// tb/tb_shift_unit_seq.sv - directed self-checking bench for shift_unit_seq
module tb_shift_unit_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] din;
  logic        busy;
  logic        done;
  logic [31:0] dout;

  int n_checks = 0;
  int n_errors = 0;

  shift_unit_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .shamt (shamt),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Issue one op; measure edges from the accepting edge to done, and busy cycles.
  // ign_at >= 0 pulses a stray start at that cycle; extra_done counts dones afterwards.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [4:0] s,
                        input logic [31:0] d, input logic [31:0] exp, input int lat,
                        input int busy_exp, input int ign_at);
    int cycles;
    int busy_cnt;
    int extra;
    @(negedge clk);
    start = 1'b1; op = o; shamt = s; din = d;
    @(posedge clk); #1;
    start = 1'b0; op = 2'b00; shamt = 5'd7; din = 32'hDEAD_BEEF;
    cycles = 0;
    busy_cnt = 0;
    while (!done && cycles < 40) begin
      if (busy) busy_cnt++;
      if (cycles == ign_at) begin
        start = 1'b1; shamt = 5'd3; din = 32'h0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    check({tag, "_lat"}, 32'(cycles), 32'(lat));
    check({tag, "_dout"}, dout, exp);
    check({tag, "_busy"}, 32'(busy_cnt), 32'(busy_exp));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    check({tag, "_hold"}, dout, exp);
    if (ign_at >= 0) begin
      extra = 0;
      for (int i = 0; i < 20; i++) begin
        if (done) extra++;
        @(posedge clk); #1;
      end
      check({tag, "_extra_done"}, 32'(extra), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; shamt = '0; din = '0;
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_dout", dout, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("sll2",  2'b00, 5'd2,  32'h0000_0002, 32'h0000_0008, 2, 1, -1);
    run_op("sra4",  2'b10, 5'd4,  32'hF0F0_0000, 32'hFF0F_0000, 3, 2, -1);
    run_op("srl4",  2'b01, 5'd4,  32'hF0F0_0000, 32'h0F0F_0000, 3, 2, -1);
    run_op("sra3",  2'b10, 5'd3,  32'h8000_0000, 32'hF000_0000, 3, 2, -1);
    run_op("srl31", 2'b01, 5'd31, 32'hFFFF_FFFF, 32'h0000_0001, 17, 16, 5);

    // shamt=0 followed by a start while the unit sits in DONE
    @(negedge clk);
    start = 1'b1; op = 2'b00; shamt = 5'd0; din = 32'h0000_1234;
    @(posedge clk); #1;
    check("b2b_first_busy", {31'b0, busy}, 32'd0);
    start = 1'b1; op = 2'b00; shamt = 5'd1; din = 32'h0000_1234;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_first_done", {31'b0, done}, 32'd1);
    check("b2b_first_dout", dout, 32'h0000_1234);
    check("b2b_second_busy", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    check("b2b_gap_done", {31'b0, done}, 32'd0);
    @(posedge clk); #1;
    check("b2b_second_done", {31'b0, done}, 32'd1);
    check("b2b_second_dout", dout, 32'h0000_2468);

    // reset in the middle of a long shift
    @(negedge clk);
    start = 1'b1; op = 2'b00; shamt = 5'd20; din = 32'h0000_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_busy_before", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_dout", dout, 32'd0);
    @(posedge clk); #1;
    check("abort_done_held", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 2'b00, 5'd20, 32'h0000_FFFF, 32'hFFF0_0000, 11, 10, -1);

`ifdef MIPS_SHIFT_ROTR_EN
    run_op("rotr4", 2'b11, 5'd4, 32'h0000_1234, 32'h4000_0123, 3, 2, -1);
    run_op("rotr1", 2'b11, 5'd1, 32'h0000_0001, 32'h8000_0000, 2, 1, -1);
`else
    run_op("op11",  2'b11, 5'd4, 32'h0000_1234, 32'h0000_1234, 1, 0, -1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
